// File: rtl/run_mode_sched_pkg.sv
// Shared mode codes, CPU exception codes and the scheduler state encoding.
// State values equal their mode codes so mode_o is the next-state value registered.
package run_mode_sched_pkg;

  localparam logic [3:0] MODE_RSTSEQ = 4'd1;
  localparam logic [3:0] MODE_ERROR  = 4'd2;
  localparam logic [3:0] MODE_PAUSE  = 4'd4;
  localparam logic [3:0] MODE_RUN    = 4'd5;
  localparam logic [3:0] MODE_UART   = 4'd6;

  localparam logic [3:0] EXC_ERR   = 4'd2;
  localparam logic [3:0] EXC_PAUSE = 4'd4;
  localparam logic [3:0] EXC_UART  = 4'd5;

  typedef enum logic [3:0] {
    ST_RSTSEQ = MODE_RSTSEQ,
    ST_ERROR  = MODE_ERROR,
    ST_PAUSE  = MODE_PAUSE,
    ST_RUN    = MODE_RUN,
    ST_UART   = MODE_UART
  } state_t;

endpackage

// File: rtl/run_mode_sched_btn_debounce.sv
// Button debouncer: 2-FF synchroniser plus stable-high counter.
// Emits one registered pulse per press once the input has been high DEB_CYCLES cycles.
module btn_debounce #(
  parameter int DEB_CYCLES = 200000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_i,
  output logic pulse_o
);

  localparam int CW = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0] TC = CW'(DEB_CYCLES);

  logic [1:0]    sync_q;
  logic [CW-1:0] cnt_q;

  // The counter parks at TC while the button stays high, which blocks a second pulse.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      pulse_o <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], btn_i};
      if (!sync_q[1]) begin
        cnt_q   <= '0;
        pulse_o <= 1'b0;
      end else if (cnt_q != TC) begin
        cnt_q   <= cnt_q + 1'b1;
        pulse_o <= (cnt_q == TC - 1'b1);
      end else begin
        pulse_o <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/run_mode_sched.sv
// Mode scheduler: debounced buttons and CPU exceptions sequence the core through
// reset, run, pause, error and UART-load modes; drives enable, reset and cycle count.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_RSTSEQ | cpu_rst_o held for RST_CYCLES cycles, then RUN
// ST_ERROR  | core halted after error; leaves only on rst or uart
// ST_PAUSE  | core halted; continue resumes
// ST_RUN    | core clocked, cycle counter advancing
// ST_UART   | core halted while loader writes memory; done/continue restart
module run_mode_sched
  import run_mode_sched_pkg::*;
#(
  parameter int DEB_CYCLES = 200000,
  parameter int RST_CYCLES = 16,
  parameter int CNT_W      = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             btn_rst_i,
  input  logic             btn_err_i,
  input  logic             btn_pause_i,
  input  logic             btn_continue_i,
  input  logic             btn_uart_i,
  input  logic [3:0]       exc_code_i,
  input  logic             exc_valid_i,
  input  logic             uart_done_i,
  input  logic             clr_cnt_i,
  output logic             cpu_en_o,
  output logic             cpu_rst_o,
  output logic [3:0]       mode_o,
  output logic [CNT_W-1:0] cycle_cnt_o
);

  localparam int TW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [TW-1:0] TMR_LOAD = TW'(RST_CYCLES - 1);

  logic [4:0] btn_raw;
  logic [4:0] btn_pulse;
  logic       p_rst, p_err, p_pause, p_cont, p_uart;

  state_t        state_q, state_nxt;
  logic [TW-1:0] tmr_q;
  logic          rstseq_entry;

  assign btn_raw = {btn_uart_i, btn_continue_i, btn_pause_i, btn_err_i, btn_rst_i};

  for (genvar i = 0; i < 5; i++) begin : g_deb
    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .btn_i   (btn_raw[i]),
      .pulse_o (btn_pulse[i])
    );
  end

  assign p_rst   = btn_pulse[0];
  assign p_err   = btn_pulse[1];
  assign p_pause = btn_pulse[2];
  assign p_cont  = btn_pulse[3];
  assign p_uart  = btn_pulse[4];

  // Priority chain: anything losing arbitration in a cycle is dropped, not queued.
  always_comb begin
    state_nxt = state_q;
    unique case (state_q)
      ST_RUN, ST_PAUSE, ST_ERROR: begin
        if (p_uart)                                state_nxt = ST_UART;
        else if (p_rst)                            state_nxt = ST_RSTSEQ;
        else if (p_err && state_q != ST_ERROR)     state_nxt = ST_ERROR;
        else if (p_pause && state_q == ST_RUN)     state_nxt = ST_PAUSE;
        else if (p_cont && state_q == ST_PAUSE)    state_nxt = ST_RUN;
        else if (exc_valid_i && state_q == ST_RUN) begin
          case (exc_code_i)
            EXC_ERR:   state_nxt = ST_ERROR;
            EXC_PAUSE: state_nxt = ST_PAUSE;
            EXC_UART:  state_nxt = ST_UART;
            default:   state_nxt = state_q;
          endcase
        end
      end
      ST_UART: begin
        if (uart_done_i || p_cont) state_nxt = ST_RSTSEQ;
      end
      ST_RSTSEQ: begin
        if (tmr_q == '0) state_nxt = ST_RUN;
      end
      default: state_nxt = ST_PAUSE;
    endcase
  end

  assign rstseq_entry = (state_nxt == ST_RSTSEQ) && (state_q != ST_RSTSEQ);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_PAUSE;
      tmr_q       <= '0;
      mode_o      <= MODE_PAUSE;
      cpu_en_o    <= 1'b0;
      cpu_rst_o   <= 1'b0;
      cycle_cnt_o <= '0;
    end else begin
      state_q   <= state_nxt;
      mode_o    <= state_nxt;
      cpu_en_o  <= (state_nxt == ST_RUN);
      cpu_rst_o <= (state_nxt == ST_RSTSEQ);

      if (rstseq_entry)
        tmr_q <= TMR_LOAD;
      else if (state_q == ST_RSTSEQ && tmr_q != '0)
        tmr_q <= tmr_q - 1'b1;

      // cpu_en_o is the registered RUN flag, so this counts cycles the core executed.
      if (clr_cnt_i || rstseq_entry)
        cycle_cnt_o <= '0;
      else if (cpu_en_o && cycle_cnt_o != '1)
        cycle_cnt_o <= cycle_cnt_o + 1'b1;
    end
  end

endmodule

// File: tb/tb_run_mode_sched.sv
// Directed bench for run_mode_sched with short debounce/reset timing and a 4-bit counter.
module tb_run_mode_sched;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] btn = '0;        // {uart, continue, pause, err, rst}
  logic [3:0] exc_code = '0;
  logic       exc_valid = 1'b0;
  logic       uart_done = 1'b0;
  logic       clr_cnt = 1'b0;
  logic       cpu_en, cpu_rst;
  logic [3:0] mode;
  logic [3:0] cnt;

  int total = 0;
  int bad = 0;

  localparam logic [4:0] B_RST = 5'b00001, B_ERR = 5'b00010, B_PAUSE = 5'b00100,
                         B_CONT = 5'b01000, B_UART = 5'b10000;

  always #5 clk = ~clk;

  run_mode_sched #(.DEB_CYCLES(4), .RST_CYCLES(3), .CNT_W(4)) dut (
    .clk_i(clk), .rst_i(rst),
    .btn_rst_i(btn[0]), .btn_err_i(btn[1]), .btn_pause_i(btn[2]),
    .btn_continue_i(btn[3]), .btn_uart_i(btn[4]),
    .exc_code_i(exc_code), .exc_valid_i(exc_valid), .uart_done_i(uart_done),
    .clr_cnt_i(clr_cnt), .cpu_en_o(cpu_en), .cpu_rst_o(cpu_rst),
    .mode_o(mode), .cycle_cnt_o(cnt)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Hold buttons from cycle 0; pulse at cycle 6; returns at cycle 7 showing the new mode.
  task automatic fire(input logic [4:0] b);
    btn = b;
    repeat (6) step();
    btn = '0;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    total++; if (mode !== 4'd4) begin bad++; $display("FAIL reset_mode got=%0d exp=4", mode); end
    total++; if ({cpu_en, cpu_rst} !== 2'b00) begin bad++; $display("FAIL reset_en_rst got=%b exp=00", {cpu_en, cpu_rst}); end
    total++; if (cnt !== 4'd0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", cnt); end
    rst = 1'b0;
    step();
    total++; if (mode !== 4'd4 || cpu_en !== 1'b0) begin bad++; $display("FAIL post_reset got mode=%0d en=%b exp mode=4 en=0", mode, cpu_en); end
  endtask

  task automatic test_start();
    btn = B_CONT;
    for (int k = 1; k <= 10; k++) begin
      step();
      total++;
      if (mode !== ((k >= 7) ? 4'd5 : 4'd4)) begin
        bad++; $display("FAIL start_mode k=%0d got=%0d exp=%0d", k, mode, (k >= 7) ? 5 : 4);
      end
      total++;
      if (cpu_en !== (k >= 7) || cnt !== ((k >= 8) ? 4'(k - 7) : 4'd0)) begin
        bad++; $display("FAIL start_en_cnt k=%0d got en=%b cnt=%0d", k, cpu_en, cnt);
      end
      if (k == 8) btn = '0;
    end
  endtask

  task automatic test_rstseq();
    fire(B_RST);
    for (int k = 7; k <= 11; k++) begin
      total++;
      if (mode !== ((k <= 9) ? 4'd1 : 4'd5) || cpu_rst !== (k <= 9) || cpu_en !== (k >= 10)) begin
        bad++; $display("FAIL rstseq k=%0d got mode=%0d rst=%b en=%b", k, mode, cpu_rst, cpu_en);
      end
      total++;
      if (cnt !== ((k == 11) ? 4'd1 : 4'd0)) begin
        bad++; $display("FAIL rstseq_cnt k=%0d got=%0d exp=%0d", k, cnt, (k == 11) ? 1 : 0);
      end
      if (k < 11) step();
    end
  endtask

  task automatic test_exc();
    exc_valid = 1'b1; exc_code = 4'd3;
    step();
    total++; if (mode !== 4'd5 || cnt !== 4'd2) begin bad++; $display("FAIL exc3 got mode=%0d cnt=%0d exp 5/2", mode, cnt); end
    exc_code = 4'd4;
    step();
    total++; if (mode !== 4'd4 || cpu_en !== 1'b0 || cnt !== 4'd3) begin bad++; $display("FAIL exc4 got mode=%0d en=%b cnt=%0d exp 4/0/3", mode, cpu_en, cnt); end
    exc_code = 4'd2;
    step();
    total++; if (mode !== 4'd4 || cnt !== 4'd3) begin bad++; $display("FAIL exc2_pause got mode=%0d cnt=%0d exp 4/3", mode, cnt); end
    exc_valid = 1'b0;
  endtask

  task automatic test_glitch_err();
    fire(B_CONT);
    total++; if (mode !== 4'd5 || cnt !== 4'd3) begin bad++; $display("FAIL resume got mode=%0d cnt=%0d exp 5/3", mode, cnt); end
    btn = B_PAUSE;
    for (int k = 1; k <= 10; k++) begin
      step();
      if (k == 3) btn = '0;
      total++; if (mode !== 4'd5) begin bad++; $display("FAIL glitch k=%0d got=%0d exp=5", k, mode); end
    end
    total++; if (cnt !== 4'd13) begin bad++; $display("FAIL glitch_cnt got=%0d exp=13", cnt); end
    fire(B_PAUSE | B_ERR);
    total++; if (mode !== 4'd2 || cpu_en !== 1'b0) begin bad++; $display("FAIL err_wins got mode=%0d en=%b exp 2/0", mode, cpu_en); end
    total++; if (cnt !== 4'd15) begin bad++; $display("FAIL saturate got=%0d exp=15", cnt); end
    fire(B_CONT);
    total++; if (mode !== 4'd2 || cnt !== 4'd15) begin bad++; $display("FAIL err_cont got mode=%0d cnt=%0d exp 2/15", mode, cnt); end
    fire(B_RST);
    total++; if (mode !== 4'd1 || cnt !== 4'd0) begin bad++; $display("FAIL err_rst got mode=%0d cnt=%0d exp 1/0", mode, cnt); end
    repeat (3) step();
    total++; if (mode !== 4'd5) begin bad++; $display("FAIL err_rst_run got=%0d exp=5", mode); end
  endtask

  task automatic test_uart();
    fire(B_UART);
    total++; if (mode !== 4'd6 || cpu_en !== 1'b0 || cnt !== 4'd7) begin bad++; $display("FAIL uart_enter got mode=%0d en=%b cnt=%0d exp 6/0/7", mode, cpu_en, cnt); end
    fire(B_RST | B_ERR);
    total++; if (mode !== 4'd6 || cnt !== 4'd7) begin bad++; $display("FAIL uart_ignore got mode=%0d cnt=%0d exp 6/7", mode, cnt); end
    exc_valid = 1'b1; exc_code = 4'd2;
    step();
    exc_valid = 1'b0;
    total++; if (mode !== 4'd6) begin bad++; $display("FAIL uart_exc got=%0d exp=6", mode); end
    btn = B_CONT;
    repeat (6) step();
    btn = '0; uart_done = 1'b1;
    step();
    uart_done = 1'b0;
    for (int k = 7; k <= 11; k++) begin
      total++;
      if (mode !== ((k <= 9) ? 4'd1 : 4'd5) || cnt !== ((k == 11) ? 4'd1 : 4'd0)) begin
        bad++; $display("FAIL uart_both k=%0d got mode=%0d cnt=%0d", k, mode, cnt);
      end
      if (k < 11) step();
    end
    fire(B_UART);
    uart_done = 1'b1;
    step();
    uart_done = 1'b0;
    total++; if (mode !== 4'd1 || cpu_rst !== 1'b1 || cnt !== 4'd0) begin bad++; $display("FAIL uart_done got mode=%0d rst=%b cnt=%0d exp 1/1/0", mode, cpu_rst, cnt); end
    repeat (3) step();
  endtask

  task automatic test_clr_abort();
    repeat (4) step();
    total++; if (mode !== 4'd5 || cnt !== 4'd4) begin bad++; $display("FAIL pre_clr got mode=%0d cnt=%0d exp 5/4", mode, cnt); end
    clr_cnt = 1'b1;
    step();
    clr_cnt = 1'b0;
    total++; if (cnt !== 4'd0) begin bad++; $display("FAIL clr got=%0d exp=0", cnt); end
    step();
    total++; if (cnt !== 4'd1) begin bad++; $display("FAIL clr_resume got=%0d exp=1", cnt); end
    fire(B_UART);
    rst = 1'b1;
    step();
    total++; if (mode !== 4'd4 || cpu_en !== 1'b0 || cnt !== 4'd0) begin bad++; $display("FAIL abort got mode=%0d en=%b cnt=%0d exp 4/0/0", mode, cpu_en, cnt); end
    rst = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_start();
    test_rstseq();
    test_exc();
    test_glitch_err();
    test_uart();
    test_clr_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
